// File: rtl/mc_sequencer_if.sv
// Control bus between the multicycle sequencer and its datapath/memory side.
// master: the sequencer. slave: the datapath, memory and run control.
interface mc_sequencer_if;
  logic        run_i;
  logic [5:0]  op_i;
  logic [5:0]  funct_i;
  logic        mem_ready_i;
  logic [2:0]  state_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        iord_o;
  logic        ir_write_o;
  logic        pc_write_o;
  logic        pc_cond_o;
  logic        reg_we_o;
  logic        retire_o;
  logic        err_o;
  logic [31:0] instr_cnt_o;

  modport master (
    input  run_i, op_i, funct_i, mem_ready_i,
    output state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o,
           pc_cond_o, reg_we_o, retire_o, err_o, instr_cnt_o
  );

  modport slave (
    output run_i, op_i, funct_i, mem_ready_i,
    input  state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o,
           pc_cond_o, reg_we_o, retire_o, err_o, instr_cnt_o
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle MIPS-style control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// memory-handshake watchdog, sticky fault state and retired-instruction count.
module mc_sequencer #(
  parameter int unsigned WDOG = 15
) (
  input  logic           clk,
  input  logic           rst,
  mc_sequencer_if.master bus
);

  localparam int unsigned    WW     = $clog2(WDOG + 2);
  localparam logic [WW-1:0]  WDOG_C = WW'(WDOG);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [WW-1:0] wd_cnt;
  logic          wd_hit;
  logic [31:0]   instr_cnt;

  logic is_legal;
  logic is_branch;
  logic is_jump;
  logic is_link;
  logic is_lw;
  logic is_sw;
  logic rt_legal;

  logic mem_req;
  logic mem_we;
  logic iord;
  logic ir_write;
  logic pc_write;
  logic pc_cond;
  logic reg_we;
  logic retire;

  assign wd_hit = (wd_cnt == WDOG_C);

  // Instruction classification from the opcode/funct fields of the IR
  always_comb begin
    rt_legal  = 1'b0;
    is_legal  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_link   = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    case (bus.funct_i)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
      6'b000110, 6'b000111, 6'b001000, 6'b001001: rt_legal = 1'b1;
      default: rt_legal = 1'b0;
    endcase
    case (bus.op_i)
      6'b000000: begin
        is_legal = rt_legal;
        is_jump  = (bus.funct_i == 6'b001000);
        is_link  = (bus.funct_i == 6'b001001);
      end
      6'b000010: begin is_legal = 1'b1; is_jump = 1'b1; end
      6'b000011: begin is_legal = 1'b1; is_link = 1'b1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        is_legal  = 1'b1;
        is_branch = 1'b1;
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111:
        is_legal = 1'b1;
      6'b100011: begin is_legal = 1'b1; is_lw = 1'b1; end
      6'b101011: begin is_legal = 1'b1; is_sw = 1'b1; end
      default: is_legal = 1'b0;
    endcase
  end

  // Next-state selection and per-state strobes (FETCH/MEM are Mealy on mem_ready_i)
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_cond   = 1'b0;
    reg_we    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (bus.run_i) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready_i) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (wd_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: state_nxt = is_legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        if (is_branch) begin
          pc_cond = 1'b1;
          retire  = 1'b1;
        end else if (is_jump) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end else if (is_link) begin
          pc_write = 1'b1;
          reg_we   = 1'b1;
          retire   = 1'b1;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        if (bus.mem_ready_i) begin
          if (is_sw) retire = 1'b1;
          else       state_nxt = S_WB;
        end else if (wd_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
    // run_i is only consulted at an instruction boundary
    if (retire) state_nxt = bus.run_i ? S_FETCH : S_IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Watchdog: counts wait cycles of the current FETCH/MEM handshake, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready_i)
      wd_cnt <= wd_cnt + 1'b1;
    else
      wd_cnt <= '0;
  end

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 32'd1;
  end

  assign bus.state_o     = state;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.iord_o      = iord;
  assign bus.ir_write_o  = ir_write;
  assign bus.pc_write_o  = pc_write;
  assign bus.pc_cond_o   = pc_cond;
  assign bus.reg_we_o    = reg_we;
  assign bus.retire_o    = retire;
  assign bus.err_o       = (state == S_ERR);
  assign bus.instr_cnt_o = instr_cnt;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter WDOG, default 15: max cycles a memory request waits for mem_ready_i before fault.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run_i  input  1  enable; 1 = fetch and execute instructions, 0 = stop at the next instruction boundary.
REQ-005 op_i  input  6  opcode field of the instruction register.
REQ-006 funct_i  input  6  funct field of the instruction register.
REQ-007 mem_ready_i  input  1  memory completes the current request this cycle.
REQ-008 state_o  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
REQ-009 mem_req_o  output  1  memory request active.
REQ-010 mem_we_o  output  1  request is a write.
REQ-011 iord_o  output  1  address select: 0 = PC, 1 = ALU result.
REQ-012 ir_write_o  output  1  load the instruction register.
REQ-013 pc_write_o  output  1  unconditional PC load.
REQ-014 pc_cond_o  output  1  PC load qualified by the datapath branch condition.
REQ-015 reg_we_o  output  1  register-file write strobe.
REQ-016 retire_o  output  1  one-cycle pulse per completed instruction.
REQ-017 err_o  output  1  sticky fault flag.
REQ-018 instr_cnt_o  output  32  retired-instruction count.

Function
REQ-019 Supported opcodes: R_TYPE 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011.
REQ-020 Supported R_TYPE funct codes: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR 001000, JALR 001001. Every other op/funct combination is illegal.
REQ-021 IDLE: all strobes are 0. Moves to FETCH when run_i=1.
REQ-022 FETCH: mem_req_o=1, mem_we_o=0, iord_o=0.
- While mem_ready_i=1: ir_write_o=1 and pc_write_o=1 (Mealy, the PC+4 update), then next state is DECODE.
- Otherwise the block stays in FETCH.
REQ-023 DECODE: one cycle, no strobes. An illegal instruction goes to ERR; any legal instruction goes to EXEC.
REQ-024 EXEC: one cycle. Actions by instruction class:
- BEQ, BNE, BLEZ, BGTZ: pc_cond_o=1, retire.
- J, JR: pc_write_o=1, retire.
- JAL, JALR: pc_write_o=1 and reg_we_o=1, retire.
- LW, SW: go to MEM.
- All other legal instructions: go to WB.
REQ-025 MEM: mem_req_o=1, iord_o=1, mem_we_o=1 only for SW. On mem_ready_i=1: SW retires; LW goes to WB.
REQ-026 WB: one cycle, reg_we_o=1, retire.
REQ-027 Retire cycle behaviour:
- retire_o=1 for that cycle.
- instr_cnt_o increments by 1 on that edge; it wraps from 0xFFFFFFFF to 0.
- Next state is FETCH if run_i=1, otherwise IDLE.
REQ-028 run_i is sampled only in IDLE and at retire. Deasserting it mid-instruction never aborts the instruction.
REQ-029 Watchdog operation:
- An internal counter clears on each entry to FETCH or MEM and increments every cycle spent there with mem_ready_i=0.
- If the counter equals WDOG with mem_ready_i=0, the next state is ERR.
- If mem_ready_i=1 in that same cycle, the handshake completes normally.
REQ-030 ERR: all strobes are 0 and err_o=1. The block stays in ERR until rst.
REQ-031 Strobe legality:
- At most one of pc_write_o and pc_cond_o is 1 in any cycle.
- mem_we_o=1 implies mem_req_o=1.
- ir_write_o=1 only in FETCH.

Reset
REQ-032 While rst=1:
- state is IDLE;
- all 1-bit outputs are 0;
- state_o=0, instr_cnt_o=0, watchdog counter is 0.
REQ-033 rst asserted in any state, including mid-handshake or ERR, takes effect immediately without a clock edge. The first edge after release evaluates from IDLE.

Verification
REQ-034 ADD with mem_ready_i tied 1, run_i=1: states 1,2,3,5, then back to 1. Four cycles per instruction, reg_we_o in WB, instr_cnt_o=1 after the first retire.
REQ-035 LW with 3-cycle memory latency on fetch and data: FETCH lasts 3 cycles and MEM lasts 3 cycles. reg_we_o pulses once in WB; retire_o pulses exactly once.
REQ-036 BEQ then JAL: pc_cond_o=1 only in the BEQ EXEC cycle. In the JAL EXEC cycle pc_write_o=1 and reg_we_o=1 together, with no WB visit.
REQ-037 Opcode 111111 loaded: DECODE goes to ERR, err_o stays 1 for 100 cycles, and rst returns state_o to 0.
REQ-038 Watchdog: mem_ready_i=0 in FETCH gives ERR after WDOG+1 cycles. In a second run, mem_ready_i=1 on the WDOG-th wait cycle gives DECODE, not ERR.
REQ-039 Boundary cases:
- run_i dropped during the MEM cycle of an SW: the SW completes, then state goes to IDLE.
- Counter preset near 0xFFFFFFFF via a long run: the retire wraps instr_cnt_o to 0.
